pulpino_fpga_io_ctrl: RTL and testbench

//  Board-side I/O and boot controller for the PULPino FPGA top: sits between raw board pins and
//  the pulpino_top instance. Per-channel GPIO synchronisation, debounce and rising-edge detection
//  for N_GPIO pins. Sequences core reset release and fetch enable from a board request switch.

---
 rtl/pulpino_fpga_pkg.sv | 22 ++
 rtl/pulpino_fpga_io_ctrl_if.sv | 27 ++
 rtl/gpio_debounce.sv | 85 ++++++++
 rtl/pulpino_fpga_io_ctrl.sv | 138 +++++++++++++
 tb/tb_pulpino_fpga_io_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulpino_fpga_pkg.sv
// Shared types and helpers for the PULPino FPGA board I/O and boot controller.
package pulpino_fpga_pkg;

  // Boot sequencer state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] boot_state_t;

  localparam boot_state_t HOLD     = 2'd0;
  localparam boot_state_t WAIT_REQ = 2'd1;
  localparam boot_state_t DELAY    = 2'd2;
  localparam boot_state_t RUN      = 2'd3;

  // Width of a counter that must hold values 0..max_count (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count == 0) ? 1 : $clog2(max_count + 1);
  endfunction

  // Larger of two parameters, used to size the shared boot counter.
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulpino_fpga_io_ctrl_if.sv
// Board-side bundle of the I/O controller: pins and switches in, core controls out.
interface pulpino_fpga_io_ctrl_if #(
  parameter int unsigned N_GPIO = 32
) ();

  logic              soft_rst_i;
  logic              fetch_req_i;
  logic [N_GPIO-1:0] gpio_pad_i;
  logic [N_GPIO-1:0] gpio_o;
  logic [N_GPIO-1:0] gpio_rise_o;
  logic              core_rst_n_o;
  logic              fetch_enable_o;
  logic              boot_done_o;

  // Board / stimulus side.
  modport master (
    output soft_rst_i, fetch_req_i, gpio_pad_i,
    input  gpio_o, gpio_rise_o, core_rst_n_o, fetch_enable_o, boot_done_o
  );

  // Controller side.
  modport slave (
    input  soft_rst_i, fetch_req_i, gpio_pad_i,
    output gpio_o, gpio_rise_o, core_rst_n_o, fetch_enable_o, boot_done_o
  );

endinterface

// File: rtl/gpio_debounce.sv
// One GPIO channel: async pad synchroniser, stability debounce, rising-edge pulse.
module gpio_debounce
  import pulpino_fpga_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   accept;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;

  // Synchroniser shift chain; the oldest stage feeds the debouncer.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign accept = (synced != level_q);
  end else begin : g_count
    localparam int unsigned    CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_c;

    // Count consecutive mismatching cycles; accept at terminal count, clear on any match.
    always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      accept_c = 1'b0;
      cnt_d    = '0;
      if (synced != level_q) begin
        if (cnt_q == TERM) begin
          accept_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Stability counter register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign accept = accept_c;
  end

  assign level_d = accept ? synced : level_q;
  assign rise_d  = accept & synced;

  // Registered debounced level and its one-cycle rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/pulpino_fpga_io_ctrl.sv
// PULPino FPGA board I/O controller: debounced GPIO into the core and the
// reset-release / fetch-enable boot sequence driven by the board fetch switch.
module pulpino_fpga_io_ctrl
  import pulpino_fpga_pkg::*;
#(
  parameter int unsigned N_GPIO          = 32,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned RST_HOLD        = 16,
  parameter int unsigned FETCH_DELAY     = 64
) (
  input logic                  clk,
  input logic                  rst,
  pulpino_fpga_io_ctrl_if.slave io
);

  localparam int unsigned      CNT_MAX    = max2(RST_HOLD, FETCH_DELAY);
  localparam int unsigned      CNT_W      = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(FETCH_DELAY - 1);

  // ---------------------------------------------------------------- GPIO
  logic [N_GPIO-1:0] gpio_level;
  logic [N_GPIO-1:0] gpio_rise;

  for (genvar g = 0; g < N_GPIO; g++) begin : g_gpio
    gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .pad_i  (io.gpio_pad_i[g]),
      .level_o(gpio_level[g]),
      .rise_o (gpio_rise[g])
    );
  end

  assign io.gpio_o      = gpio_level;
  assign io.gpio_rise_o = gpio_rise;

  // ---------------------------------------------------------- fetch switch
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   req_s;

  // Fetch request switch synchroniser (level signal, no debounce).
  always_ff @(posedge clk) begin
    if (rst) begin
      req_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], io.fetch_req_i};
    end
  end

  assign req_s = req_sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------- boot FSM
  boot_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             core_rst_n_q, core_rst_n_d;
  logic             fetch_en_q, fetch_en_d;
  logic             boot_done_q, boot_done_d;

  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  // Next state and shared cycle counter; soft reset overrides every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_REQ;
          cnt_d   = '0;
        end
      end
      WAIT_REQ: begin
        cnt_d = '0;
        if (req_s) begin
          state_d = (FETCH_DELAY == 0) ? RUN : DELAY;
        end
      end
      DELAY: begin
        if (!req_s) begin
          state_d = WAIT_REQ;
          cnt_d   = '0;
        end else if (cnt_q == DELAY_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!req_s) begin
          state_d = WAIT_REQ;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
    if (io.soft_rst_i) begin
      state_d = HOLD;
      cnt_d   = '0;
    end
  end

  // Outputs are registered from the next state so they change on the transition edge.
  always_comb begin
    core_rst_n_d = (state_d != HOLD);
    fetch_en_d   = (state_d == RUN);
    boot_done_d  = io.soft_rst_i ? 1'b0 : (boot_done_q | fetch_en_d);
  end

  // Boot sequencer state and registered core controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      boot_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_en_q   <= fetch_en_d;
      boot_done_q  <= boot_done_d;
    end
  end

  assign io.core_rst_n_o   = core_rst_n_q;
  assign io.fetch_enable_o = fetch_en_q;
  assign io.boot_done_o    = boot_done_q;

endmodule

// File: tb/tb_pulpino_fpga_io_ctrl.sv
// Bench for the PULPino FPGA I/O controller: two configurations driven with the
// same stimulus, each checked every cycle against a window/streak model, plus
// literal timing checks on the default configuration.
module tb_pulpino_fpga_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_rst;
  logic        fetch_req;
  logic [31:0] gpio_pad;

  logic [31:0] gpio_o_w [2];
  logic [31:0] rise_w   [2];
  logic        rstn_w   [2];
  logic        fen_w    [2];
  logic        done_w   [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // cfg0: defaults. cfg1: 3-stage sync, debounce bypassed, shortest boot timings.
  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int S  = (k == 0) ? 2    : 3;
    localparam int D  = (k == 0) ? 1000 : 0;
    localparam int RH = (k == 0) ? 16   : 1;
    localparam int FD = (k == 0) ? 64   : 0;

    pulpino_fpga_io_ctrl_if #(.N_GPIO(32)) bus ();

    assign bus.soft_rst_i  = soft_rst;
    assign bus.fetch_req_i = fetch_req;
    assign bus.gpio_pad_i  = gpio_pad;

    pulpino_fpga_io_ctrl #(
      .N_GPIO         (32),
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D),
      .RST_HOLD       (RH),
      .FETCH_DELAY    (FD)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .io (bus)
    );

    assign gpio_o_w[k] = bus.gpio_o;
    assign rise_w[k]   = bus.gpio_rise_o;
    assign rstn_w[k]   = bus.core_rst_n_o;
    assign fen_w[k]    = bus.fetch_enable_o;
    assign done_w[k]   = bus.boot_done_o;

    // Model state: pad/request delay lines, debounce window, boot streak counters.
    logic [31:0] m_gpio, m_rise;
    logic        m_rst_n, m_fen, m_done;
    logic [31:0] pad_pipe [$];
    logic        req_pipe [$];
    logic [31:0] win [$];
    int          since_rel, streak;
    bit          started = 1'b0;

    // Model: a level change is accepted once the last D synchronised samples all
    // disagree with it; fetch is enabled after FD+1 consecutive request samples
    // seen while the core is out of reset.
    always @(posedge clk) begin
      logic [31:0] x, all1, any1, upd;
      logic        rs;
      bit          up_before;
      started = 1'b1;
      if (rst) begin
        pad_pipe = {};
        req_pipe = {};
        win      = {};
        for (int i = 0; i < S; i++) begin
          pad_pipe.push_back('0);
          req_pipe.push_back(1'b0);
        end
        m_gpio = '0; m_rise = '0;
        since_rel = 0; streak = 0;
        m_rst_n = 1'b0; m_fen = 1'b0; m_done = 1'b0;
      end else begin
        x  = pad_pipe.pop_front();
        pad_pipe.push_back(gpio_pad);
        rs = req_pipe.pop_front();
        req_pipe.push_back(fetch_req);

        if (D == 0) begin
          upd = x ^ m_gpio;
        end else begin
          win.push_back(x);
          if (win.size() > D) void'(win.pop_front());
          upd = '0;
          if (win.size() == D) begin
            all1 = '1;
            any1 = '0;
            foreach (win[j]) begin
              all1 &= win[j];
              any1 |= win[j];
            end
            upd = (all1 & ~m_gpio) | (~any1 & m_gpio);
          end
        end
        m_rise = upd & ~m_gpio;
        m_gpio = m_gpio ^ upd;

        if (soft_rst) begin
          since_rel = 0;
          streak    = 0;
          m_done    = 1'b0;
        end else begin
          up_before = (since_rel >= RH);
          if (since_rel < RH) since_rel++;
          if (up_before && rs) begin
            if (streak < 1000000) streak++;
          end else begin
            streak = 0;
          end
        end
        m_rst_n = (since_rel >= RH);
        m_fen   = (streak >= FD + 1);
        if (m_fen) m_done = 1'b1;
      end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
      if (started) begin
        check($sformatf("cfg%0d gpio_o", k),         bus.gpio_o,         m_gpio);
        check($sformatf("cfg%0d gpio_rise_o", k),    bus.gpio_rise_o,    m_rise);
        check($sformatf("cfg%0d core_rst_n_o", k),   bus.core_rst_n_o,   m_rst_n);
        check($sformatf("cfg%0d fetch_enable_o", k), bus.fetch_enable_o, m_fen);
        check($sformatf("cfg%0d boot_done_o", k),    bus.boot_done_o,    m_done);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    soft_rst  = 1'b0;
    fetch_req = 1'b0;
    gpio_pad  = '0;
    cyc(5);
    check("reset gpio_o", gpio_o_w[0], 32'h0);
    check("reset core_rst_n", rstn_w[0], 1'b0);
    rst = 1'b0;

    // 1: core reset released exactly RST_HOLD edges after rst drops.
    cyc(15);
    check("t1 core_rst_n at 15", rstn_w[0], 1'b0);
    cyc(1);
    check("t1 core_rst_n at 16", rstn_w[0], 1'b1);
    check("t1 fetch_enable idle", fen_w[0], 1'b0);

    // 2: fetch request -> 2 sync + WAIT->DELAY + 64 delay edges.
    fetch_req = 1'b1;
    cyc(66);
    check("t2 fetch_enable at 66", fen_w[0], 1'b0);
    cyc(1);
    check("t2 fetch_enable at 67", fen_w[0], 1'b1);
    check("t2 boot_done at 67", done_w[0], 1'b1);
    cyc(5);
    fetch_req = 1'b0;
    cyc(2);
    check("t2 fetch_enable after drop+2", fen_w[0], 1'b1);
    cyc(1);
    check("t2 fetch_enable after drop+3", fen_w[0], 1'b0);
    check("t2 boot_done sticky", done_w[0], 1'b1);

    // 3: debounced rise on pad 3, then a 999-cycle glitch that must be ignored.
    gpio_pad[3] = 1'b1;
    cyc(1001);
    check("t3 gpio_o[3] at 1001", gpio_o_w[0][3], 1'b0);
    cyc(1);
    check("t3 gpio_o[3] at 1002", gpio_o_w[0][3], 1'b1);
    check("t3 rise[3] pulse", rise_w[0][3], 1'b1);
    cyc(1);
    check("t3 rise[3] one cycle", rise_w[0][3], 1'b0);
    gpio_pad[3] = 1'b0;
    cyc(999);
    gpio_pad[3] = 1'b1;
    cyc(1100);
    check("t3 glitch ignored", gpio_o_w[0][3], 1'b1);

    // 4: bypassed debounce with 3-stage sync follows pad after 4 edges.
    gpio_pad[0] = 1'b1;
    cyc(3);
    check("t4 bypass gpio_o[0] at 3", gpio_o_w[1][0], 1'b0);
    cyc(1);
    check("t4 bypass gpio_o[0] at 4", gpio_o_w[1][0], 1'b1);
    check("t4 bypass rise[0]", rise_w[1][0], 1'b1);
    gpio_pad[0] = 1'b0;
    cyc(4);
    check("t4 bypass fall", gpio_o_w[1][0], 1'b0);
    check("t4 bypass no fall pulse", rise_w[1][0], 1'b0);

    // 5: soft reset in RUN, then re-boot with the request still held.
    fetch_req = 1'b1;
    cyc(70);
    check("t5 in RUN", fen_w[0], 1'b1);
    soft_rst = 1'b1;
    cyc(1);
    check("t5 soft core_rst_n", rstn_w[0], 1'b0);
    check("t5 soft fetch_enable", fen_w[0], 1'b0);
    check("t5 soft boot_done", done_w[0], 1'b0);
    soft_rst = 1'b0;
    cyc(15);
    check("t5 reboot core_rst_n at 15", rstn_w[0], 1'b0);
    cyc(1);
    check("t5 reboot core_rst_n at 16", rstn_w[0], 1'b1);
    cyc(64);
    check("t5 reboot fetch at 80", fen_w[0], 1'b0);
    cyc(1);
    check("t5 reboot fetch at 81", fen_w[0], 1'b1);
    check("t5 reboot boot_done", done_w[0], 1'b1);

    // Random phase: sparse pad toggles, request toggles, occasional soft-reset bursts.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 32; b++) begin
        if ($urandom_range(699, 0) == 0) gpio_pad[b] = ~gpio_pad[b];
      end
      if ($urandom_range(79, 0) == 0) fetch_req = ~fetch_req;
      soft_rst = ($urandom_range(299, 0) == 0) ? 1'b1
                                               : (soft_rst & ($urandom_range(1, 0) == 1));
      cyc(1);
    end
    soft_rst  = 1'b0;
    fetch_req = 1'b0;

    // 6: all pads toggle together, rst mid-debounce, pads high through reset.
    gpio_pad = '1;
    cyc(1100);
    check("t6 all high settled", gpio_o_w[0], 32'hFFFF_FFFF);
    gpio_pad = '0;
    cyc(500);
    rst      = 1'b1;
    gpio_pad = '1;
    cyc(3);
    check("t6 rst gpio_o", gpio_o_w[0], 32'h0);
    check("t6 rst rise", rise_w[0], 32'h0);
    check("t6 rst core_rst_n", rstn_w[0], 1'b0);
    check("t6 rst fetch_enable", fen_w[0], 1'b0);
    check("t6 rst boot_done", done_w[0], 1'b0);
    rst = 1'b0;
    cyc(1001);
    check("t6 gpio_o at 1001", gpio_o_w[0], 32'h0);
    cyc(1);
    check("t6 gpio_o at 1002", gpio_o_w[0], 32'hFFFF_FFFF);
    check("t6 rise at 1002", rise_w[0], 32'hFFFF_FFFF);
    cyc(1);
    check("t6 rise cleared", rise_w[0], 32'h0);
    cyc(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
